// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_pkg;

    localparam int COUNTDOWN_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle Done pulse on expiry.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic auto-reload from the last nonzero load.
//
// state  | meaning
// IDLE   | waiting for LoadEn; CountOut holds its last value
// RUN    | decrementing on each CountIn cycle
// EXPIRE | count reached zero; Done high for this one cycle
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = COUNTDOWN_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             LoadEn,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             CountIn,
    input  logic             Abort,
    output logic [WIDTH-1:0] CountOut,
    output logic             Busy,
    output logic             Done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0]   reload_q, reload_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (Abort) begin
            state_d = IDLE;
            count_d = '0;
        end else if (LoadEn) begin
            count_d = LoadVal;
            state_d = (LoadVal != '0) ? RUN : EXPIRE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            // A zero load clears the reload value so that it expires only once.
            reload_d = LoadVal;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (CountIn) begin
                        if (count_q <= WIDTH'(1)) begin
                            count_d = '0;
                            state_d = EXPIRE;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                EXPIRE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (reload_q != '0) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == EXPIRE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign CountOut = count_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (WIDTH=4); one-shot and auto-reload builds.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       LoadEn;
    logic [3:0] LoadVal;
    logic       CountIn;
    logic       Abort;
    logic [3:0] CountOut;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];

    countdown_timer #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .LoadEn   (LoadEn),
        .LoadVal  (LoadVal),
        .CountIn  (CountIn),
        .Abort    (Abort),
        .CountOut (CountOut),
        .Busy     (Busy),
        .Done     (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic le, input logic [3:0] lv, input logic ci, input logic ab,
                        input logic [3:0] ec, input logic eb, input logic ed, input string tag);
        exp_t e;
        @(negedge clk);
        LoadEn  = le;
        LoadVal = lv;
        CountIn = ci;
        Abort   = ab;
        e.cnt  = ec;
        e.busy = eb;
        e.done = ed;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".cnt"},  CountOut, e.cnt);
            check({e.tag, ".busy"}, Busy,     e.busy);
            check({e.tag, ".done"}, Done,     e.done);
        end
    end

    initial begin
        rst = 1'b1;
        LoadEn = 1'b0; LoadVal = '0; CountIn = 1'b0; Abort = 1'b0;
        #3;
        check("rst.cnt",  CountOut, 0);
        check("rst.busy", Busy, 0);
        check("rst.done", Done, 0);
        @(negedge clk);
        rst = 1'b0;

        step(0, 0, 1, 0, 0, 0, 0, "idle_ignore");

        // one-shot expiry
        step(1, 3, 1, 0, 3, 1, 0, "os_k");
        step(0, 0, 1, 0, 2, 1, 0, "os_k1");
        step(0, 0, 1, 0, 1, 1, 0, "os_k2");
        step(0, 0, 1, 0, 0, 1, 1, "os_k3");
        step(0, 0, 1, 0, AR ? 4'd3 : 4'd0, AR, 0, "os_k4");
        step(0, 0, 0, 1, 0, 0, 0, "os_clr");

        // gapped ticks
        step(1, 2, 0, 0, 2, 1, 0, "gap_ld");
        step(0, 0, 1, 0, 1, 1, 0, "gap_1");
        step(0, 0, 0, 0, 1, 1, 0, "gap_0a");
        step(0, 0, 0, 0, 1, 1, 0, "gap_0b");
        step(0, 0, 1, 0, 0, 1, 1, "gap_exp");
        step(0, 0, 0, 0, AR ? 4'd2 : 4'd0, AR, 0, "gap_post");
        step(0, 0, 0, 1, 0, 0, 0, "gap_clr");

        // reload mid-run
        step(1, 7, 1, 0, 7, 1, 0, "rl_ld");
        step(0, 0, 1, 0, 6, 1, 0, "rl_6");
        step(0, 0, 1, 0, 5, 1, 0, "rl_5");
        step(1, 15, 1, 0, 15, 1, 0, "rl_15");
        step(0, 0, 1, 0, 14, 1, 0, "rl_14");
        step(0, 0, 0, 1, 0, 0, 0, "rl_abort");

        // abort beats load and tick
        step(1, 4, 0, 0, 4, 1, 0, "ab_ld");
        step(0, 0, 1, 0, 3, 1, 0, "ab_3");
        step(0, 0, 1, 0, 2, 1, 0, "ab_2");
        step(1, 9, 1, 1, 0, 0, 0, "ab_hit");
        step(0, 0, 1, 0, 0, 0, 0, "ab_idle");

        // zero load expires at once
        step(1, 0, 1, 0, 0, 1, 1, "z_ld");
        step(0, 0, 0, 0, 0, 0, 0, "z_post");

        // load during EXPIRE restarts
        step(1, 1, 1, 0, 1, 1, 0, "ex_ld");
        step(0, 0, 1, 0, 0, 1, 1, "ex_exp");
        step(1, 2, 1, 0, 2, 1, 0, "ex_reld");
        step(0, 0, 1, 0, 1, 1, 0, "ex_1");
        step(0, 0, 0, 1, 0, 0, 0, "ex_clr");

        // asynchronous reset mid-run
        step(1, 7, 0, 0, 7, 1, 0, "ar_ld");
        @(negedge clk);
        LoadEn = 1'b0; LoadVal = '0; CountIn = 1'b0; Abort = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst.cnt",  CountOut, 0);
        check("arst.busy", Busy, 0);
        check("arst.done", Done, 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 0, 0, 0, "arst_ci1");
        step(0, 0, 1, 0, 0, 0, 0, "arst_ci2");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        step(1, 2, 1, 0, 2, 1, 0, "per_ld");
        step(0, 0, 1, 0, 1, 1, 0, "per_1a");
        step(0, 0, 1, 0, 0, 1, 1, "per_0a");
        step(0, 0, 1, 0, 2, 1, 0, "per_2b");
        step(0, 0, 1, 0, 1, 1, 0, "per_1b");
        step(0, 0, 1, 0, 0, 1, 1, "per_0b");
        step(0, 0, 1, 0, 2, 1, 0, "per_2c");
        step(0, 0, 1, 1, 0, 0, 0, "per_abort");
        step(0, 0, 1, 0, 0, 0, 0, "per_idle");
`endif

        step(0, 0, 0, 0, 0, 0, 0, "tail");
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the count width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port LoadEn, input, 1, a request to load LoadVal and start counting.
REQ-005 The block SHALL have port LoadVal, input, WIDTH, the start value, sampled when LoadEn=1.
REQ-006 The block SHALL have port CountIn, input, 1, the tick enable; each high cycle in RUN decrements the count by one.
REQ-007 The block SHALL have port Abort, input, 1, which cancels the count with no Done.
REQ-008 The block SHALL have port CountOut, output, WIDTH, the current count (registered).
REQ-009 The block SHALL have port Busy, output, 1, high whenever state is not IDLE (registered).
REQ-010 The block SHALL have port Done, output, 1, a one-cycle expiry pulse (registered).

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and EXPIRE.
REQ-012 In IDLE, LoadEn=1 with LoadVal!=0 SHALL set CountOut<=LoadVal and move to RUN; CountIn SHALL be ignored in IDLE.
REQ-013 In IDLE, LoadEn=1 with LoadVal==0 SHALL set CountOut<=0 and move directly to EXPIRE.
REQ-014 In RUN, CountIn=1 SHALL decrement CountOut by 1; CountIn=0 SHALL hold CountOut.
REQ-015 In RUN, CountIn=1 with CountOut==1 SHALL set CountOut<=0 and move to EXPIRE; CountOut SHALL never wrap below 0.
REQ-016 Done SHALL be high exactly for the cycle the FSM is in EXPIRE; EXPIRE SHALL last one cycle, then go to IDLE (subject to REQ-024).
REQ-017 LoadEn=1 in RUN or EXPIRE SHALL restart counting: it loads LoadVal, follows REQ-012/013 targets, takes priority over CountIn, and suppresses the EXPIRE-to-IDLE exit.
REQ-018 Abort=1 in any state SHALL set CountOut<=0 and move to IDLE with no Done, taking priority over LoadEn and CountIn.
REQ-019 CountOut SHALL retain its last value in IDLE until the next load, abort or reset.

Reset
REQ-020 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, CountOut=0, Busy=0, Done=0, and the reload register=0.
REQ-021 Reset asserted mid-RUN SHALL discard the count; after release the block SHALL remain in IDLE until LoadEn.

Configuration
REQ-022 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select the auto-reload feature.
REQ-023 Without COUNTDOWN_AUTO_RELOAD_EN, the block SHALL behave as one-shot per REQ-016 and SHALL contain no reload register.
REQ-024 With COUNTDOWN_AUTO_RELOAD_EN, every accepted nonzero load SHALL be stored in the reload register, and EXPIRE SHALL set CountOut<=reload and return to RUN, giving periodic Done until Abort; a zero load SHALL behave one-shot.

Structure
REQ-025 Package countdown_pkg SHALL hold the FSM state typedef (IDLE, RUN, EXPIRE) and the default WIDTH constant.
REQ-026 The block SHALL have no sub-module; the FSM and down-count datapath SHALL be in a single module.

Verification (WIDTH=4)
REQ-027 The bench SHALL cover one-shot expiry: load 3 at edge k with CountIn held at 1 -> CountOut 3,2,1,0 at edges k..k+3; Done=1 for one cycle after k+3; Busy falls at k+4.
REQ-028 The bench SHALL cover a gapped tick: load 2 with CountIn pattern 1,0,0,1 -> CountOut 2,1,1,1,0; Done once.
REQ-029 The bench SHALL cover a reload mid-run: at CountOut=5, LoadEn with LoadVal=15 -> CountOut=15 the next edge, stays RUN, and no Done is emitted for the first count.
REQ-030 The bench SHALL cover abort and zero load: Abort at CountOut=2 -> CountOut=0, IDLE, Done never asserted; LoadVal=0 load -> Done pulse on the next cycle and Busy high for one cycle.
REQ-031 The bench SHALL cover asynchronous reset: rst asserted between edges at CountOut=7 -> CountOut=0 and Busy=0 before the next edge; CountIn pulses after release -> CountOut stays 0.
REQ-032 With COUNTDOWN_AUTO_RELOAD_EN, the bench SHALL check that loading 2 with CountIn held at 1 -> Done every 3 cycles and CountOut sequence 2,1,0,2,1,0, with Abort stopping it.
